pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 4-stage pipelined CPU (IF, ID, EX/MEM, WB).
- Tracks in-flight register writes in internal EX and WB shadow slots and stalls PC and IF/ID on read-after-write hazards.
- Injects bubbles into ID/EX and kills wrong-path fetches after a taken branch or jump redirect.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- RADDR_W, 6, register-address width (64 registers).
- WB_WRITE_THROUGH, 1: 1 means the register file returns the same-cycle WB write on read, so WB matches are not hazards; 0 means WB matches also stall.
- ZERO_REG_EXEMPT, 0: 1 means reg 0 never causes a hazard.
- CNT_W, 16, performance-counter width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- id_rd  in  RADDR_W  destination register of the ID instruction (inst[27:22]).
- id_rs1  in  RADDR_W  source 1 of the ID instruction (inst[21:16]).
- id_rs2  in  RADDR_W  source 2 of the ID instruction (inst[15:10]).
- id_rs1_used  in  1  ID instruction reads rs1 (includes jump/branch target reads).
- id_rs2_used  in  1  ID instruction reads rs2.
- id_regwrt  in  1  ID instruction writes rd (control regwrt).
- redirect  in  1  branch/jump taken this cycle (the jump/branch OR output).
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID capture enable.
- idex_bubble  out  1  zero all ID/EX control bits captured at this edge.
- id_valid  out  1  ID slot holds a valid, non-flushed instruction.
- stall  out  1  RAW hazard detected this cycle.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of flushes.

Behaviour:
- State:
  - id_v: ID-slot valid.
  - EX shadow: ex_v, ex_rd, ex_wr.
  - WB shadow: wb_v, wb_rd, wb_wr.
  - stall_cnt and flush_cnt.
- Reset (rst_n=0 at edge):
  - All shadows and id_v cleared; counters = 0.
  - While rst_n=0, outputs are forced: pc_write=0, ifid_write=0, idex_bubble=1, stall=0.
- match(s, v, wr, rd) = v & wr & (s==rd) & ~(ZERO_REG_EXEMPT & s==0).
- hazard (combinational) = id_v & ((id_rs1_used & M1) | (id_rs2_used & M2)).
  - Mx = match against EX, OR match against WB when WB_WRITE_THROUGH=0.
- Outputs (combinational from state and inputs, rst_n=1):
  - stall = hazard.
  - pc_write = ~stall; ifid_write = ~stall.
  - idex_bubble = stall | ~id_v.
- take = redirect & id_v & ~stall. Redirect is ignored when stalled or when ID is invalid; it is re-evaluated once operands are ready.
- Sequential update at each posedge (rst_n=1):
  - WB shadow <= EX shadow, every cycle.
  - EX shadow <= {id_v & ~stall, id_rd, id_regwrt & id_v & ~stall}. A stall inserts a bubble (ex_v=0).
  - id_v <= stall ? id_v : ~take.
    - Hold while stalled.
    - A taken redirect kills the wrong-path instruction captured at this edge.
    - Otherwise the next cycle is valid.
  - First cycle after reset: id_v=0, so a bubble is inserted.
- Latency:
  - A hazard on an EX producer stalls 1 cycle with WB_WRITE_THROUGH=1, and 2 cycles with 0.
  - Redirect costs exactly 1 bubble.
- Counters:
  - stall_cnt +1 on each cycle with stall=1.
  - flush_cnt +1 on each take.
  - Both saturate at all-ones; no wrap.
- Simultaneous events:
  - stall beats redirect.
  - Both rs1 and rs2 matching produces one stall, not two.
  - Reset mid-stall or mid-flush clears everything immediately at that edge.
- An instruction with regwrt=0 never creates a hazard for younger readers.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> pc_write=0, ifid_write=0, idex_bubble=1, counters=0. First cycle after release: id_valid=0, idex_bubble=1, pc_write=1.
- RAW on EX, WB_WRITE_THROUGH=1:
  - Stimulus: ADD r5 (regwrt=1), then a reader with id_rs1=5 and rs1_used=1.
  - Response: exactly 1 cycle with stall=1, pc_write=0, idex_bubble=1; the next cycle proceeds; stall_cnt=1.
- Same sequence with WB_WRITE_THROUGH=0 -> 2 consecutive stall cycles; stall_cnt=2. Reader with rs2=5 but rs2_used=0 -> no stall.
- Redirect:
  - Stimulus: redirect=1 with id_v=1 and no hazard.
  - Response: next cycle id_valid=0 and idex_bubble=1; flush_cnt=1; no write-enable from the killed instruction reaches the EX shadow.
- Redirect during stall:
  - Stimulus: jump reading r7 while r7 is in EX, redirect=1.
  - Response: no flush counted while stalled; flush_cnt increments only in the cycle after the stall clears.
- Saturation and zero-reg exemption:
  - Run with CNT_W=4 and a continuous hazard for 20 cycles -> stall_cnt=15 and holds.
  - With ZERO_REG_EXEMPT=1, a write of r0 followed by a read of r0 -> no stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW stall, redirect flush and perf counters for the 4-stage CPU
module pipeline_hazard_ctrl #(
    parameter int unsigned RADDR_W          = 6,
    parameter int unsigned WB_WRITE_THROUGH = 1,
    parameter int unsigned ZERO_REG_EXEMPT  = 0,
    parameter int unsigned CNT_W            = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               id_rs1_used,
    input  logic               id_rs2_used,
    input  logic               id_regwrt,
    input  logic               redirect,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               idex_bubble,
    output logic               id_valid,
    output logic               stall,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic               id_v_q, id_v_d;
    logic               ex_v_q, ex_v_d;
    logic [RADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic               ex_wr_q, ex_wr_d;
    logic               wb_v_q, wb_v_d;
    logic [RADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic               wb_wr_q, wb_wr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               hazard;
    logic               m1;
    logic               m2;
    logic               take;

    // A shadow slot matches a source when it holds a real write to that register
    function automatic logic slot_match(input logic [RADDR_W-1:0] s, input logic v,
                                        input logic wr, input logic [RADDR_W-1:0] rd);
        logic exempt;
        exempt = (ZERO_REG_EXEMPT != 0) && (s == '0);
        return v & wr & (s == rd) & ~exempt;
    endfunction

    // Hazard detection; the WB slot only counts when the regfile cannot forward its write
    always_comb begin
        m1 = slot_match(id_rs1, ex_v_q, ex_wr_q, ex_rd_q);
        m2 = slot_match(id_rs2, ex_v_q, ex_wr_q, ex_rd_q);
        if (WB_WRITE_THROUGH == 0) begin
            m1 = m1 | slot_match(id_rs1, wb_v_q, wb_wr_q, wb_rd_q);
            m2 = m2 | slot_match(id_rs2, wb_v_q, wb_wr_q, wb_rd_q);
        end
        hazard = id_v_q & ((id_rs1_used & m1) | (id_rs2_used & m2));
        take   = redirect & id_v_q & ~hazard;
    end

    // Pipeline enables; reset holds the front end and bubbles ID/EX
    always_comb begin
        stall       = 1'b0;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        if (rst_n) begin
            stall       = hazard;
            pc_write    = ~hazard;
            ifid_write  = ~hazard;
            idex_bubble = hazard | ~id_v_q;
        end
        id_valid  = id_v_q;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

    // Next-state: shadows advance every cycle, a stall issues a bubble into EX
    always_comb begin
        wb_v_d  = ex_v_q;
        wb_rd_d = ex_rd_q;
        wb_wr_d = ex_wr_q;
        ex_v_d  = id_v_q & ~hazard;
        ex_rd_d = id_rd;
        ex_wr_d = id_regwrt & id_v_q & ~hazard;
        id_v_d  = hazard ? id_v_q : ~take;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (take && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_v_q      <= 1'b0;
            ex_v_q      <= 1'b0;
            ex_rd_q     <= '0;
            ex_wr_q     <= 1'b0;
            wb_v_q      <= 1'b0;
            wb_rd_q     <= '0;
            wb_wr_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            id_v_q      <= id_v_d;
            ex_v_q      <= ex_v_d;
            ex_rd_q     <= ex_rd_d;
            ex_wr_q     <= ex_wr_d;
            wb_v_q      <= wb_v_d;
            wb_rd_q     <= wb_rd_d;
            wb_wr_q     <= wb_wr_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
